// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared psum bank geometry defaults and FSM state encodings
package psum_pkg;
    localparam int PSUM_SMALL_BANK_COUNT = 3;
    localparam int PSUM_BIG_BANK_COUNT   = 3;
    localparam int PSUM_SMALL_THRESHOLD  = 16;
    localparam int PSUM_ADDR_WIDTH       = 8;
    localparam int PSUM_GPR_WIDTH        = 6;

    typedef enum logic [1:0] {
        PSUM_IDLE   = 2'd0,
        PSUM_ALLOC  = 2'd1,
        PSUM_WRITE  = 2'd2,
        PSUM_COMMIT = 2'd3
    } psum_state_e;
endpackage

// File: rtl/psum_bank_alloc.sv
// rtl/psum_bank_alloc.sv - combinational priority search for a reusable or free psum bank
module psum_bank_alloc
    import psum_pkg::*;
#(
    parameter int SMALL_BANK_COUNT = PSUM_SMALL_BANK_COUNT,
    parameter int BIG_BANK_COUNT   = PSUM_BIG_BANK_COUNT,
    parameter int SMALL_THRESHOLD  = PSUM_SMALL_THRESHOLD,
    parameter int ADDR_WIDTH       = PSUM_ADDR_WIDTH,
    parameter int GPR_WIDTH        = PSUM_GPR_WIDTH,
    parameter int TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT,
    parameter int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT)
) (
    input  logic [TOTAL_BANK_COUNT-1:0]           bank_valid,
    input  logic [TOTAL_BANK_COUNT*GPR_WIDTH-1:0] bank_op_id_flat,
    input  logic [GPR_WIDTH-1:0]                  op_id,
    input  logic [ADDR_WIDTH-1:0]                 seq_len,
    output logic                                  match_found,
    output logic [BANK_INDEX_WIDTH-1:0]           match_idx,
    output logic                                  free_found,
    output logic [BANK_INDEX_WIDTH-1:0]           free_idx
);
    localparam logic [ADDR_WIDTH-1:0] THRESH = ADDR_WIDTH'(SMALL_THRESHOLD);

    logic fits_small;

    // Loops run high-to-low so the last hit written is the lowest index.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        fits_small  = (seq_len <= THRESH);
        for (int k = TOTAL_BANK_COUNT - 1; k >= 0; k--) begin
            if (bank_valid[k] && (bank_op_id_flat[k*GPR_WIDTH +: GPR_WIDTH] == op_id)) begin
                match_found = 1'b1;
                match_idx   = BANK_INDEX_WIDTH'(k);
            end
        end
        for (int k = TOTAL_BANK_COUNT - 1; k >= SMALL_BANK_COUNT; k--) begin
            if (!bank_valid[k]) begin
                free_found = 1'b1;
                free_idx   = BANK_INDEX_WIDTH'(k);
            end
        end
        // A free small bank overrides the big-bank candidate for short sequences.
        if (fits_small) begin
            for (int k = SMALL_BANK_COUNT - 1; k >= 0; k--) begin
                if (!bank_valid[k]) begin
                    free_found = 1'b1;
                    free_idx   = BANK_INDEX_WIDTH'(k);
                end
            end
        end
    end
endmodule

// File: rtl/psum_writer.sv
// rtl/psum_writer.sv - allocates a psum bank per sequence and streams beat writes into it
module psum_writer
    import psum_pkg::*;
#(
    parameter int SMALL_BANK_COUNT = PSUM_SMALL_BANK_COUNT,
    parameter int BIG_BANK_COUNT   = PSUM_BIG_BANK_COUNT,
    parameter int SMALL_THRESHOLD  = PSUM_SMALL_THRESHOLD,
    parameter int ADDR_WIDTH       = PSUM_ADDR_WIDTH,
    parameter int GPR_WIDTH        = PSUM_GPR_WIDTH,
    parameter int TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT,
    parameter int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_write,
    input  logic [GPR_WIDTH-1:0]                  write_operation_id,
    input  logic [ADDR_WIDTH-1:0]                 write_seq_length,
    input  logic                                  psum_in_valid,
    input  logic                                  stall,
    input  logic [TOTAL_BANK_COUNT-1:0]           bank_clear_in,
    output logic                                  busy,
    output logic                                  req_accepted,
    output logic                                  req_rejected,
    output logic                                  no_free_bank,
    output logic                                  write_valid,
    output logic                                  write_accumulate,
    output logic [ADDR_WIDTH-1:0]                 psum_write_address,
    output logic [BANK_INDEX_WIDTH-1:0]           psum_bank_index,
    output logic [TOTAL_BANK_COUNT*GPR_WIDTH-1:0] bank_op_id_flat,
    output logic [TOTAL_BANK_COUNT-1:0]           bank_valid
);
    psum_state_e                          state_q, state_d;
    logic [GPR_WIDTH-1:0]                 op_id_q, op_id_d;
    logic [ADDR_WIDTH-1:0]                len_q, len_d;
    logic [ADDR_WIDTH-1:0]                cnt_q, cnt_d;
    logic [BANK_INDEX_WIDTH-1:0]          bank_idx_q, bank_idx_d;
    logic                                 accum_q, accum_d;
    logic [TOTAL_BANK_COUNT-1:0]          bank_valid_q, bank_valid_d;
    logic [TOTAL_BANK_COUNT*GPR_WIDTH-1:0] bank_op_id_q, bank_op_id_d;
    logic                                 busy_q, busy_d;
    logic                                 req_accepted_q, req_accepted_d;
    logic                                 req_rejected_q, req_rejected_d;
    logic                                 no_free_bank_q, no_free_bank_d;
    logic                                 write_valid_q, write_valid_d;
    logic                                 write_accumulate_q, write_accumulate_d;
    logic [ADDR_WIDTH-1:0]                wr_addr_q, wr_addr_d;

    logic [TOTAL_BANK_COUNT-1:0]          valid_eff;
    logic [TOTAL_BANK_COUNT-1:0]          owned_mask;
    logic                                 match_found, free_found;
    logic [BANK_INDEX_WIDTH-1:0]          match_idx, free_idx;
    logic                                 beat_accept, last_beat, len_zero;

    // Same-cycle clears are applied before the search sees the banks.
    assign valid_eff   = bank_valid_q & ~bank_clear_in;
    assign beat_accept = (state_q == PSUM_WRITE) && psum_in_valid && !stall;
    assign last_beat   = (cnt_q == (len_q - ADDR_WIDTH'(1)));
    assign len_zero    = (len_q == '0);

    psum_bank_alloc #(
        .SMALL_BANK_COUNT (SMALL_BANK_COUNT),
        .BIG_BANK_COUNT   (BIG_BANK_COUNT),
        .SMALL_THRESHOLD  (SMALL_THRESHOLD),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .GPR_WIDTH        (GPR_WIDTH),
        .TOTAL_BANK_COUNT (TOTAL_BANK_COUNT),
        .BANK_INDEX_WIDTH (BANK_INDEX_WIDTH)
    ) u_alloc (
        .bank_valid      (valid_eff),
        .bank_op_id_flat (bank_op_id_q),
        .op_id           (op_id_q),
        .seq_len         (len_q),
        .match_found     (match_found),
        .match_idx       (match_idx),
        .free_found      (free_found),
        .free_idx        (free_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= PSUM_IDLE;
            op_id_q            <= '0;
            len_q              <= '0;
            cnt_q              <= '0;
            bank_idx_q         <= '0;
            accum_q            <= 1'b0;
            bank_valid_q       <= '0;
            bank_op_id_q       <= '0;
            busy_q             <= 1'b0;
            req_accepted_q     <= 1'b0;
            req_rejected_q     <= 1'b0;
            no_free_bank_q     <= 1'b0;
            write_valid_q      <= 1'b0;
            write_accumulate_q <= 1'b0;
            wr_addr_q          <= '0;
        end else begin
            state_q            <= state_d;
            op_id_q            <= op_id_d;
            len_q              <= len_d;
            cnt_q              <= cnt_d;
            bank_idx_q         <= bank_idx_d;
            accum_q            <= accum_d;
            bank_valid_q       <= bank_valid_d;
            bank_op_id_q       <= bank_op_id_d;
            busy_q             <= busy_d;
            req_accepted_q     <= req_accepted_d;
            req_rejected_q     <= req_rejected_d;
            no_free_bank_q     <= no_free_bank_d;
            write_valid_q      <= write_valid_d;
            write_accumulate_q <= write_accumulate_d;
            wr_addr_q          <= wr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_id_d    = op_id_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        bank_idx_d = bank_idx_q;
        accum_d    = accum_q;
        case (state_q)
            PSUM_IDLE: begin
                if (start_write) begin
                    op_id_d = write_operation_id;
                    len_d   = write_seq_length;
                    state_d = PSUM_ALLOC;
                end
            end
            PSUM_ALLOC: begin
                cnt_d = '0;
                if (len_zero) begin
                    state_d = PSUM_IDLE;
                end else if (match_found) begin
                    bank_idx_d = match_idx;
                    accum_d    = 1'b1;
                    state_d    = PSUM_WRITE;
                end else if (free_found) begin
                    bank_idx_d = free_idx;
                    accum_d    = 1'b0;
                    state_d    = PSUM_WRITE;
                end else begin
                    state_d = PSUM_IDLE;
                end
            end
            PSUM_WRITE: begin
                if (beat_accept) begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                    if (last_beat) state_d = PSUM_COMMIT;
                end
            end
            PSUM_COMMIT: state_d = PSUM_IDLE;
            default:     state_d = PSUM_IDLE;
        endcase
    end

    // The bank being written is shielded from reader clears until it commits.
    always_comb begin
        owned_mask   = ((state_q == PSUM_WRITE) || (state_q == PSUM_COMMIT))
                     ? (TOTAL_BANK_COUNT'(1) << bank_idx_q) : '0;
        bank_valid_d = bank_valid_q & ~(bank_clear_in & ~owned_mask);
        bank_op_id_d = bank_op_id_q;
        if (state_q == PSUM_COMMIT) begin
            bank_valid_d[bank_idx_q]                         = 1'b1;
            bank_op_id_d[bank_idx_q*GPR_WIDTH +: GPR_WIDTH] = op_id_q;
        end
    end

    always_comb begin
        busy_d             = (state_d != PSUM_IDLE);
        req_accepted_d     = (state_q == PSUM_ALLOC) && !len_zero && (match_found || free_found);
        no_free_bank_d     = (state_q == PSUM_ALLOC) && !len_zero && !match_found && !free_found;
        req_rejected_d     = ((state_q == PSUM_ALLOC) && len_zero)
                           || ((state_q != PSUM_IDLE) && start_write);
        write_valid_d      = beat_accept;
        write_accumulate_d = beat_accept && accum_q;
        wr_addr_d          = beat_accept ? cnt_q : wr_addr_q;
    end

    assign busy               = busy_q;
    assign req_accepted       = req_accepted_q;
    assign req_rejected       = req_rejected_q;
    assign no_free_bank       = no_free_bank_q;
    assign write_valid        = write_valid_q;
    assign write_accumulate   = write_accumulate_q;
    assign psum_write_address = wr_addr_q;
    assign psum_bank_index    = bank_idx_q;
    assign bank_op_id_flat    = bank_op_id_q;
    assign bank_valid         = bank_valid_q;
endmodule

// File: tb/tb_psum_writer.sv
// tb/tb_psum_writer.sv - scoreboard bench for psum_writer with directed sequences
module tb_psum_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_write = 1'b0;
    logic [5:0]  write_operation_id = '0;
    logic [7:0]  write_seq_length = '0;
    logic        psum_in_valid = 1'b0;
    logic        stall = 1'b0;
    logic [5:0]  bank_clear_in = '0;
    logic        busy, req_accepted, req_rejected, no_free_bank;
    logic        write_valid, write_accumulate;
    logic [7:0]  psum_write_address;
    logic [2:0]  psum_bank_index;
    logic [35:0] bank_op_id_flat;
    logic [5:0]  bank_valid;

    int checks = 0;
    int errors = 0;
    logic [11:0] wq[$];
    logic [2:0]  sq[$];

    localparam logic [2:0] ST_ACC = 3'b100;
    localparam logic [2:0] ST_REJ = 3'b010;
    localparam logic [2:0] ST_NFB = 3'b001;

    psum_writer dut (
        .clk                (clk),
        .reset              (reset),
        .start_write        (start_write),
        .write_operation_id (write_operation_id),
        .write_seq_length   (write_seq_length),
        .psum_in_valid      (psum_in_valid),
        .stall              (stall),
        .bank_clear_in      (bank_clear_in),
        .busy               (busy),
        .req_accepted       (req_accepted),
        .req_rejected       (req_rejected),
        .no_free_bank       (no_free_bank),
        .write_valid        (write_valid),
        .write_accumulate   (write_accumulate),
        .psum_write_address (psum_write_address),
        .psum_bank_index    (psum_bank_index),
        .bank_op_id_flat    (bank_op_id_flat),
        .bank_valid         (bank_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [11:0] got_w, exp_w;
        logic [2:0]  got_s, exp_s;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (write_valid) begin
                    got_w = {psum_bank_index, psum_write_address, write_accumulate};
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected actual=%0h expected=none", got_w);
                    end else begin
                        exp_w = wq.pop_front();
                        if (got_w !== exp_w) begin
                            errors++;
                            $display("FAIL write_beat actual=%0h expected=%0h", got_w, exp_w);
                        end
                    end
                end
                got_s = {req_accepted, req_rejected, no_free_bank};
                if (got_s != 3'b000) begin
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL status_unexpected actual=%b expected=none", got_s);
                    end else begin
                        exp_s = sq.pop_front();
                        if (got_s !== exp_s) begin
                            errors++;
                            $display("FAIL status actual=%b expected=%b", got_s, exp_s);
                        end
                    end
                end
            end
        end
    endtask

    task automatic start_req(input int id, input int len, input logic [5:0] alloc_clr, output bit got);
        sq.push_back(ST_ACC);
        start_write        = 1'b1;
        write_operation_id = 6'(id);
        write_seq_length   = 8'(len);
        tick();
        start_write   = 1'b0;
        bank_clear_in = alloc_clr;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick();
            bank_clear_in = '0;
            if (req_accepted) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=none expected=req_accepted id=%0d", id);
        end
    endtask

    task automatic drive_beats(input int len, input int bank, input int acc, input int stall_at,
                               input int clr_at, input logic [5:0] clr_mask, input logic [5:0] clr_exp,
                               input int rej_at);
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                psum_in_valid = 1'b1;
                stall = 1'b1;
                repeat (3) tick();
                stall = 1'b0;
            end
            if (i == rej_at) begin
                start_write        = 1'b1;
                write_operation_id = 6'd33;
                write_seq_length   = 8'd2;
                sq.push_back(ST_REJ);
            end
            if (i == clr_at) bank_clear_in = clr_mask;
            psum_in_valid = 1'b1;
            wq.push_back({3'(bank), 8'(i), 1'(acc)});
            tick();
            start_write   = 1'b0;
            bank_clear_in = '0;
            psum_in_valid = 1'b0;
            if (i == clr_at) check("clear_effect", bank_valid & clr_mask, clr_exp);
        end
    endtask

    task automatic run_seq(input int id, input int len, input int bank, input int acc,
                           input int stall_at, input int clr_at, input logic [5:0] clr_mask,
                           input logic [5:0] clr_exp, input int rej_at, input logic [5:0] alloc_clr,
                           input logic [5:0] exp_valid);
        bit got;
        start_req(id, len, alloc_clr, got);
        if (got) begin
            drive_beats(len, bank, acc, stall_at, clr_at, clr_mask, clr_exp, rej_at);
            repeat (3) tick();
            check("bank_valid", bank_valid, exp_valid);
            check("bank_op_id", bank_op_id_flat[bank*6 +: 6], id);
            check("busy_after", busy, 0);
        end
    endtask

    task automatic try_fail(input int id, input int len, input logic [2:0] code);
        sq.push_back(code);
        start_write        = 1'b1;
        write_operation_id = 6'(id);
        write_seq_length   = 8'(len);
        tick();
        start_write = 1'b0;
        repeat (4) tick();
        check("busy_after_fail", busy, 0);
    endtask

    initial begin
        bit got;
        fork
            monitor();
        join_none
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_write_valid", write_valid, 0);
        check("rst_status", {req_accepted, req_rejected, no_free_bank}, 0);
        check("rst_bank_valid", bank_valid, 0);
        check("rst_op_ids", bank_op_id_flat, 0);
        check("rst_addr_idx", {psum_write_address, psum_bank_index}, 0);
        reset = 1'b0;
        tick();

        run_seq(5,  4,  0, 0, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b000001);
        run_seq(5,  4,  0, 1, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b000001);
        run_seq(9,  3,  1, 0, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b000011);
        run_seq(7,  20, 3, 0, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b001011);
        run_seq(10, 16, 2, 0, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b001111);
        run_seq(11, 17, 4, 0, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b011111);
        run_seq(12, 18, 5, 0, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b111111);
        try_fail(13, 20, ST_NFB);
        try_fail(14, 4,  ST_NFB);

        run_seq(5, 6, 0, 1, 2, 1, 6'b000010, 6'b000000, 4, 6'h00, 6'b111101);
        run_seq(5, 2, 0, 1, -1, 0, 6'b000001, 6'b000001, -1, 6'h00, 6'b111101);
        run_seq(9, 2, 1, 0, -1, -1, 6'h00, 6'h00, -1, 6'h00, 6'b111111);
        try_fail(3, 0, ST_REJ);
        run_seq(20, 2, 2, 0, -1, -1, 6'h00, 6'h00, -1, 6'b000100, 6'b111111);

        bank_clear_in = 6'b001000;
        tick();
        bank_clear_in = '0;
        check("idle_clear", bank_valid, 6'b110111);
        check("idle_clear_keeps_id", bank_op_id_flat[18 +: 6], 7);

        start_req(21, 4, 6'h00, got);
        if (got) begin
            drive_beats(2, 3, 0, -1, -1, 6'h00, 6'h00, -1);
            tick();
            tick();
            check("mid_write_busy", busy, 1);
            reset = 1'b1;
            #1;
            check("abort_bank_valid", bank_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_op_ids", bank_op_id_flat, 0);
            tick();
            reset = 1'b0;
            repeat (3) tick();
            check("abort_no_commit", bank_valid, 0);
        end

        repeat (3) tick();
        check("write_queue_empty", wq.size(), 0);
        check("status_queue_empty", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
